// File: rtl/lifo_pkg.sv
// Shared constants and types for the lifo stack buffer.
// Holds the default geometry, the pointer-width helper and the request decode encoding.
package lifo_pkg;

    localparam int LIFO_WIDTH = 16;
    localparam int LIFO_DEPTH = 4;

    // The stack pointer must represent every count from 0 up to DEPTH inclusive.
    function automatic int ptr_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    typedef enum logic [1:0] {
        OP_IDLE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } lifo_op_e;

endpackage

// File: rtl/lifo_mem.sv
// Register-array storage for the stack.
// It has one synchronous write port and one asynchronous read port. The contents are not reset.
module lifo_mem
    import lifo_pkg::*;
#(
    parameter int WIDTH = LIFO_WIDTH,
    parameter int DEPTH = LIFO_DEPTH,
    parameter int AW    = addr_width(LIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read is combinational, so the top-of-stack word can be captured on the same edge as a replace write.
    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo.sv
// This is a synchronous LIFO stack with registered read data and count-derived flags.
// The top-of-stack word is mem[sp-1]. A simultaneous push and pop replaces the top entry.
module lifo
    import lifo_pkg::*;
#(
    parameter int WIDTH = LIFO_WIDTH,
    parameter int DEPTH = LIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = addr_width(DEPTH);

    logic [PW-1:0]    sp;
    logic [PW-1:0]    sp_next;
    lifo_op_e         op;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    mem_raddr;
    logic [WIDTH-1:0] mem_rdata;

    assign empty = (sp == '0);
    assign full  = (sp == PW'(DEPTH));

    // A push and pop on an empty stack degrades to a plain push. On a non-empty stack, including a full one, it becomes a replace.
    always_comb begin
        op = OP_IDLE;
        if (push && pop) begin
            op = empty ? OP_PUSH : OP_REPLACE;
        end else if (push && !full) begin
            op = OP_PUSH;
        end else if (pop && !empty) begin
            op = OP_POP;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = AW'(sp);
        mem_raddr = AW'(sp - PW'(1));
        sp_next   = sp;
        case (op)
            OP_PUSH: begin
                mem_we    = 1'b1;
                mem_waddr = AW'(sp);
                sp_next   = sp + PW'(1);
            end
            OP_POP: begin
                sp_next = sp - PW'(1);
            end
            OP_REPLACE: begin
                mem_we    = 1'b1;
                mem_waddr = AW'(sp - PW'(1));
            end
            default: begin
                sp_next = sp;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= '0;
        end else begin
            sp <= sp_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
        end else if (op == OP_POP || op == OP_REPLACE) begin
            data_out <= mem_rdata;
        end
    end

    lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (data_in),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_lifo.sv
// Self-checking bench for lifo: directed vectors with literal expectations, plus a
// queue-based reference model compared against the DUT outputs on every falling edge.
module tb_lifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 1'b0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] model_dout;

    lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The reference stack tracks the occupancy and the last popped word.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_q.delete();
            model_dout = '0;
        end else if (push && pop && model_q.size() > 0) begin
            model_dout = model_q[model_q.size() - 1];
            model_q[model_q.size() - 1] = data_in;
        end else if (push && model_q.size() < DEPTH) begin
            model_q.push_back(data_in);
        end else if (pop && !push && model_q.size() > 0) begin
            model_dout = model_q.pop_back();
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            tests_run++;
            if (empty !== (model_q.size() == 0) || full !== (model_q.size() == DEPTH)
                || data_out !== model_dout) begin
                tests_failed++;
                $display("[TB] FAIL model_cmp @%0t: empty=%0b full=%0b data_out=%h, expected empty=%0b full=%0b data_out=%h",
                         $time, empty, full, data_out, model_q.size() == 0,
                         model_q.size() == DEPTH, model_dout);
            end
        end
    end

    task automatic applyStimulus(input logic p, input logic q, input logic [WIDTH-1:0] d);
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic exp_empty, input logic exp_full,
                               input logic [WIDTH-1:0] exp_dout);
        tests_run++;
        if (empty !== exp_empty || full !== exp_full || data_out !== exp_dout) begin
            tests_failed++;
            $display("[TB] FAIL %s: empty=%0b full=%0b data_out=%h, expected empty=%0b full=%0b data_out=%h",
                     name, empty, full, data_out, exp_empty, exp_full, exp_dout);
        end
    endtask

    initial begin
        rst     = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b1, 1'b0, 16'h0000);
        rst      = 1'b1;
        check_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("idle_after_reset", 1'b1, 1'b0, 16'h0000);

        applyStimulus(1'b1, 1'b0, 16'h1111);
        checkOutput("fill1", 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h2222);
        checkOutput("fill2", 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h3333);
        checkOutput("fill3", 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h4444);
        checkOutput("fill4_full", 1'b0, 1'b1, 16'h0000);

        applyStimulus(1'b1, 1'b0, 16'hDEAD);
        checkOutput("overflow_ignored", 1'b0, 1'b1, 16'h0000);

        applyStimulus(1'b0, 1'b1, 16'h0000);
        checkOutput("drain1", 1'b0, 1'b0, 16'h4444);
        applyStimulus(1'b0, 1'b1, 16'h0000);
        checkOutput("drain2", 1'b0, 1'b0, 16'h3333);
        applyStimulus(1'b0, 1'b1, 16'h0000);
        checkOutput("drain3", 1'b0, 1'b0, 16'h2222);
        applyStimulus(1'b0, 1'b1, 16'h0000);
        checkOutput("drain4_empty", 1'b1, 1'b0, 16'h1111);

        applyStimulus(1'b0, 1'b1, 16'h0000);
        checkOutput("underflow_hold", 1'b1, 1'b0, 16'h1111);

        applyStimulus(1'b1, 1'b0, 16'hAAAA);
        checkOutput("push_aaaa", 1'b0, 1'b0, 16'h1111);
        applyStimulus(1'b1, 1'b1, 16'hBBBB);
        checkOutput("replace_top", 1'b0, 1'b0, 16'hAAAA);
        applyStimulus(1'b0, 1'b1, 16'h0000);
        checkOutput("pop_replaced", 1'b1, 1'b0, 16'hBBBB);

        applyStimulus(1'b1, 1'b0, 16'h0101);
        applyStimulus(1'b1, 1'b0, 16'h0202);
        applyStimulus(1'b1, 1'b0, 16'h0303);
        applyStimulus(1'b1, 1'b0, 16'h0404);
        checkOutput("refill_full", 1'b0, 1'b1, 16'hBBBB);
        applyStimulus(1'b1, 1'b1, 16'h0C0C);
        checkOutput("replace_when_full", 1'b0, 1'b1, 16'h0404);
        applyStimulus(1'b0, 1'b1, 16'h0000);
        checkOutput("pop_after_full_replace", 1'b0, 1'b0, 16'h0C0C);
        applyStimulus(1'b0, 1'b1, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0000);
        checkOutput("drain_refill", 1'b1, 1'b0, 16'h0101);

        applyStimulus(1'b1, 1'b1, 16'h5555);
        checkOutput("both_when_empty", 1'b0, 1'b0, 16'h0101);
        applyStimulus(1'b0, 1'b1, 16'h0000);
        checkOutput("pop_after_both_empty", 1'b1, 1'b0, 16'h5555);

        applyStimulus(1'b1, 1'b0, 16'h7777);
        applyStimulus(1'b1, 1'b0, 16'h8888);
        checkOutput("two_pushed", 1'b0, 1'b0, 16'h5555);
        rst = 1'b0;
        #1;
        checkOutput("async_reset_immediate", 1'b1, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held", 1'b1, 1'b0, 16'h0000);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 16'h0000);

        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
